cache_tile_walker: RTL and testbench

CACHE_TILE_WALKER -- requirements
Module: cache_tile_walker

---
 rtl/cache_tile_walker_pkg.sv | 20 ++
 rtl/cache_tile_range.sv | 23 ++
 rtl/cache_tile_walker.sv | 82 ++++++++
 tb/tb_cache_tile_walker.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cache_tile_walker_pkg.sv
// cache_tile_walker_pkg: shared cache configuration, walker state encoding and tile-width helper
package cache_tile_walker_pkg;

    localparam int CFG_X_ADDR_WDTH = 12;
    localparam int CFG_Y_ADDR_WDTH = 12;
    localparam int CFG_SHIFT_H     = 3;
    localparam int CFG_SHIFT_V     = 3;
    localparam int CFG_DIM_WDTH    = 4;
    localparam int C_L_H_SIZE      = 1 << CFG_SHIFT_H;
    localparam int C_L_V_SIZE      = 1 << CFG_SHIFT_V;
    localparam int NOW_X_WDTH      = CFG_X_ADDR_WDTH - CFG_SHIFT_H;
    localparam int NOW_Y_WDTH      = CFG_Y_ADDR_WDTH - CFG_SHIFT_V;

    typedef enum logic {IDLE, WALK} walk_state_t;

    function automatic int now_wdth(input int addr_wdth, input int shift);
        return addr_wdth - shift;
    endfunction

endpackage

// File: rtl/cache_tile_range.sv
// cache_tile_range: first/last tile index of one axis, last index clamped at the top of the address space
module cache_tile_range
    import cache_tile_walker_pkg::*;
#(
    parameter int ADDR_WDTH = CFG_X_ADDR_WDTH,
    parameter int SHIFT     = CFG_SHIFT_H,
    parameter int DIM_WDTH  = CFG_DIM_WDTH,
    localparam int NOW_WDTH = now_wdth(ADDR_WDTH, SHIFT)
) (
    input  logic [ADDR_WDTH-1:0] start,
    input  logic [DIM_WDTH-1:0]  dim,
    output logic [NOW_WDTH-1:0]  tile_start,
    output logic [NOW_WDTH-1:0]  tile_end
);

    logic [ADDR_WDTH:0] sum;

    assign sum        = {1'b0, start} + (ADDR_WDTH+1)'(dim);
    assign tile_start = start[ADDR_WDTH-1:SHIFT];
    // a carry out means the block runs past the last column; stop there instead of wrapping
    assign tile_end   = sum[ADDR_WDTH] ? '1 : sum[ADDR_WDTH-1:SHIFT];

endmodule

// File: rtl/cache_tile_walker.sv
// cache_tile_walker: walks every cache-line tile covered by a pixel block in raster order
module cache_tile_walker
    import cache_tile_walker_pkg::*;
#(
    parameter int X_ADDR_WDTH = CFG_X_ADDR_WDTH,
    parameter int Y_ADDR_WDTH = CFG_Y_ADDR_WDTH,
    parameter int SHIFT_H     = CFG_SHIFT_H,
    parameter int SHIFT_V     = CFG_SHIFT_V,
    parameter int DIM_WDTH    = CFG_DIM_WDTH,
    localparam int NOW_X_WDTH = now_wdth(X_ADDR_WDTH, SHIFT_H),
    localparam int NOW_Y_WDTH = now_wdth(Y_ADDR_WDTH, SHIFT_V)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_ADDR_WDTH-1:0] start_x,
    input  logic [Y_ADDR_WDTH-1:0] start_y,
    input  logic [DIM_WDTH-1:0]    blk_width,
    input  logic [DIM_WDTH-1:0]    blk_height,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NOW_X_WDTH-1:0]  x_addr,
    output logic [NOW_Y_WDTH-1:0]  y_addr,
    output logic                   out_last
);

    walk_state_t           state;
    logic [NOW_X_WDTH-1:0] x_start, x_end, rx_start, rx_end, nx;
    logic [NOW_Y_WDTH-1:0] y_end, ry_start, ry_end, ny;
    logic                  adv, x_wrap;

    cache_tile_range #(.ADDR_WDTH(X_ADDR_WDTH), .SHIFT(SHIFT_H), .DIM_WDTH(DIM_WDTH)) u_range_x (
        .start(start_x), .dim(blk_width), .tile_start(rx_start), .tile_end(rx_end)
    );

    cache_tile_range #(.ADDR_WDTH(Y_ADDR_WDTH), .SHIFT(SHIFT_V), .DIM_WDTH(DIM_WDTH)) u_range_y (
        .start(start_y), .dim(blk_height), .tile_start(ry_start), .tile_end(ry_end)
    );

    assign out_valid = state == WALK;
    assign adv       = out_valid && out_ready;
    // the last handshake reopens the input so the next block follows without a bubble
    assign in_ready  = !flush && (state == IDLE || (adv && out_last));
    assign x_wrap    = x_addr == x_end;
    assign nx        = x_wrap ? x_start : x_addr + 1'b1;
    assign ny        = x_wrap ? y_addr + 1'b1 : y_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            x_addr   <= '0;
            y_addr   <= '0;
            x_start  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            out_last <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            out_last <= 1'b0;
        end else if (in_valid && in_ready) begin
            state    <= WALK;
            x_addr   <= rx_start;
            y_addr   <= ry_start;
            x_start  <= rx_start;
            x_end    <= rx_end;
            y_end    <= ry_end;
            out_last <= rx_start == rx_end && ry_start == ry_end;
        end else if (adv) begin
            if (out_last) begin
                state    <= IDLE;
                out_last <= 1'b0;
            end else begin
                x_addr   <= nx;
                y_addr   <= ny;
                out_last <= nx == x_end && ny == y_end;
            end
        end
    end

endmodule

// File: tb/tb_cache_tile_walker.sv
// tb_cache_tile_walker: directed and random blocks checked against a tile-list reference model
module tb_cache_tile_walker;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic        in_ready, out_valid, out_last;
    logic [11:0] start_x, start_y;
    logic [3:0]  blk_width, blk_height;
    logic [8:0]  x_addr, y_addr;

    typedef struct {int x; int y; bit last;} tile_t;
    tile_t exp_q[$];
    int vectors = 0;
    int errs = 0;
    int nb_sx, nb_w, nb_sy, nb_h;

    cache_tile_walker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .start_x(start_x), .start_y(start_y), .blk_width(blk_width), .blk_height(blk_height),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .x_addr(x_addr), .y_addr(y_addr), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // expected tile list straight from the pixel-range arithmetic
    task automatic model(input int sx, input int w, input int sy, input int h);
        int xs, xe, ys, ye;
        xs = sx / 8;
        xe = (sx + w) / 8;
        ys = sy / 8;
        ye = (sy + h) / 8;
        if (xe > 511) xe = 511;
        if (ye > 511) ye = 511;
        for (int yy = ys; yy <= ye; yy++)
            for (int xx = xs; xx <= xe; xx++)
                exp_q.push_back('{x: xx, y: yy, last: (xx == xe && yy == ye)});
    endtask

    task automatic request(input int sx, input int w, input int sy, input int h);
        int n = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        start_x    = 12'(sx);
        blk_width  = 4'(w);
        start_y    = 12'(sy);
        blk_height = 4'(h);
        model(sx, w, sy, h);
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int mode, input bit b2b);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            @(negedge clk);
            guard++;
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (guard % 2 == 1) : 1'($urandom % 2);
            #1;
            chk("valid", out_valid, 1);
            chk("x", x_addr, exp_q[0].x);
            chk("y", y_addr, exp_q[0].y);
            chk("last", out_last, exp_q[0].last);
            chk("in_ready", in_ready, exp_q[0].last && out_ready);
            if (out_ready && exp_q[0].last && b2b) begin
                in_valid   = 1'b1;
                start_x    = 12'(nb_sx);
                blk_width  = 4'(nb_w);
                start_y    = 12'(nb_sy);
                blk_height = 4'(nb_h);
            end
            if (out_ready) void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        start_x = '0; start_y = '0; blk_width = '0; blk_height = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_x", x_addr, 0);
        chk("rst_y", y_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle("post_rst");

        request(5, 7, 16, 3);      drain(0, 0); check_idle("two_tiles");
        request(8, 7, 8, 7);       drain(0, 0); check_idle("single");
        request(4090, 15, 0, 0);   drain(0, 0); check_idle("x_clamp");
        request(0, 0, 4092, 15);   drain(0, 0); check_idle("y_clamp");
        request(4, 15, 4, 15);     drain(1, 0); check_idle("stall");

        // back-to-back: next request rides on the last handshake
        nb_sx = 100; nb_w = 9; nb_sy = 200; nb_h = 12;
        request(5, 7, 16, 3);
        drain(0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        model(nb_sx, nb_w, nb_sy, nb_h);
        drain(0, 0);
        check_idle("b2b");

        // flush mid-walk while stalled
        request(0, 15, 0, 15);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1 chk("flush_valid", out_valid, 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk); out_ready = 1'b1;
            #1 chk("flush_quiet", out_valid, 0);
        end

        // asynchronous reset mid-walk
        request(0, 15, 0, 15);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_last", out_last, 0);
        chk("arst_x", x_addr, 0);
        exp_q.delete();
        @(negedge clk); reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 chk("arst_quiet", out_valid, 0);
        end

        for (int i = 0; i < 25; i++) begin
            request(int'($urandom % 4096), int'($urandom % 16), int'($urandom % 4096), int'($urandom % 16));
            drain(2, 0);
        end
        check_idle("random_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
